frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Shares the single-port LED frame-buffer RAM between the display scan-out path and the host write path, and manages double-buffer swapping at frame boundaries. The RAM holds two banks. Scan-out always reads the front bank, and host writes always target the back bank. Scan reads have absolute priority because the panel shift timing cannot stall; host writes drain through a one-entry holding register in idle cycles. Sits between the host loader, the scan sequencer (which supplies `scan_req`/`frame_start`) and the RAM.

## Interface
- `ADDR_W`, 12, per-bank address width.
- `DATA_W`, 24, word width (8b red, 8b green, 8b blue).
- `STARVE_MAX`, 1024, wait cycles before `host_starved` sets.
- `clk` in 1 — single clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `scan_req` in 1 — scan read request, one word per cycle.
- `scan_addr` in ADDR_W — scan read address.
- `scan_rdata` out DATA_W — read data, registered.
- `scan_rvalid` out 1 — `scan_rdata` valid.
- `frame_start` in 1 — single-cycle pulse at the start of each frame.
- `host_wr_valid` in 1 — host write offer.
- `host_wr_ready` out 1 — arbiter accepts a write this cycle.
- `host_wr_addr` in ADDR_W — back-bank write address.
- `host_wr_data` in DATA_W — write data.
- `swap_req` in 1 — pulse; request a front/back swap.
- `swap_done` out 1 — single-cycle pulse in the cycle `front_bank` toggles.
- `front_bank` out 1 — current front bank.
- `clear_status` in 1 — clears `host_starved`.
- `host_starved` out 1 — sticky starvation flag.
- `mem_en` out 1 — RAM enable.
- `mem_we` out 1 — RAM write enable.
- `mem_addr` out ADDR_W+1 — RAM address; the MSB is the bank bit.
- `mem_wdata` out DATA_W — RAM write data.
- `mem_rdata` in DATA_W — RAM read data, 1-cycle synchronous read.

## Operation
**Host write path**
- A write is accepted when `host_wr_valid & host_wr_ready`. Address and data are captured into the holding register, and `hold_full` sets.
- `host_wr_ready = !hold_full & !swap_pend`.

**RAM arbitration (combinational)**
- `mem_en = scan_req | hold_full`.
- `mem_we = hold_full & !scan_req`.
- Scan access: `mem_addr = {front_bank, scan_addr}`.
- Host write: `mem_addr = {~front_bank, hold_addr}` and `mem_wdata = hold_data`.
- Scan always wins. A write issues in the first cycle where `scan_req=0`, and `hold_full` clears at the end of that cycle.

**Read return**
- `scan_rdata`/`scan_rvalid` are registered from `mem_rdata` and the delayed `scan_req`.

**Swap FSM (IDLE, PEND)**
- IDLE → PEND on `swap_req`.
- PEND → IDLE on `frame_start & !hold_full`: `front_bank` toggles and `swap_done` pulses in the same cycle.
- `swap_req` in PEND is ignored.
- A `swap_req` coincident with `frame_start` in IDLE enters PEND. It swaps no earlier than the next `frame_start`.
- A `frame_start` arriving while `hold_full=1` defers the swap to the following `frame_start`.

**Starvation monitor**
- A counter increments each cycle `hold_full & scan_req`, saturates at STARVE_MAX, and clears on write issue.
- When the counter reaches STARVE_MAX, `host_starved` sets. It stays set until `clear_status`.
- If set and clear occur in the same cycle, set wins.

## Timing
- Scan read latency: `scan_req` at cycle N gives `scan_rvalid=1` with data at N+2. It is fully pipelined, so back-to-back requests return back-to-back.
- Write-hazard timing:
  - Accept at N gives the earliest RAM write at N+1.
  - `host_wr_ready` is low in N+1 and returns high in N+2 if the write issued in N+1.
  - Peak host throughput is one write per 2 cycles.
- `front_bank` change is visible to scan addressing in the cycle after the `swap_done` pulse. Reads already in flight complete with old-bank data.
- Reset values: `front_bank=0`, swap FSM in IDLE, `hold_full=0`, `swap_done=0`, `scan_rvalid=0`, `scan_rdata=0`, `host_starved=0`, starve counter 0.
- Asynchronous reset assertion mid-operation discards the held write and any pending swap.
- `host_wr_ready` is 1 in the first cycle after reset deassertion.

## Structure
- The shared package `cube_pkg` holds `ADDR_W`/`DATA_W` defaults, a `swap_state_t` enum (IDLE, PEND) and an `rgb_word_t` typedef.
- One sub-module, `saturating_counter` (parameters N and MAX; ports clk, reset_n, inc, clr, count, at_max), implements the starvation counter.
- Everything else is inline.

## Test plan
- **Reset:** assert `reset_n=0` mid-write with `hold_full=1` → all outputs read their reset values, and no `mem_we` fires after release.
- **Idle write:** no scan traffic, write addr 0x010 data 0xFF8000 at cycle N → `mem_we=1` with `mem_addr=0x1010` at N+1, and ready is high again at N+2.
- **Scan read:** `scan_req` for 4 consecutive cycles addr 0..3 with a host write pending → 4 `scan_rvalid` beats at N+2..N+5 from bank 0; the write issues in the first gap.
- **Swap:**
  - `swap_req`, then `frame_start` with `hold_full=1` → no swap.
  - Next `frame_start` → `swap_done` pulses and `front_bank=1`.
  - Subsequent scan reads use `mem_addr` MSB=1.
  - Ready stays low throughout PEND.
- **Starvation:** STARVE_MAX=8, continuous `scan_req` with a write held → `host_starved=1` once 8 wait cycles have elapsed and stays set after the write drains; `clear_status` clears it, and simultaneous set/clear leaves it set.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared types and default widths for the LED cube frame-buffer slice.
package cube_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_word_t;

endpackage

// File: rtl/frame_buffer_arbiter_saturating_counter.sv
// Up-counter that sticks at MAX; clear has priority over increment.
module saturating_counter #(
  parameter int N   = 11,
  parameter int MAX = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [N-1:0] count,
  output logic         at_max
);

  assign at_max = (count == N'(MAX));

  // Count up on inc until MAX, return to zero on clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + N'(1);
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares the single-port frame-buffer RAM between scan-out reads (front bank,
// absolute priority) and buffered host writes (back bank), and swaps banks at
// frame boundaries on request.
module frame_buffer_arbiter #(
  parameter int ADDR_W     = cube_pkg::ADDR_W,
  parameter int DATA_W     = cube_pkg::DATA_W,
  parameter int STARVE_MAX = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_rvalid,
  input  logic              frame_start,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_bank,
  input  logic              clear_status,
  output logic              host_starved,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import cube_pkg::*;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  swap_state_t       state_q;
  swap_state_t       state_d;
  logic              swap_fire;
  logic              hold_full;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              scan_req_d;
  logic              accept;
  logic              write_issue;
  logic              starve_inc;
  logic              starve_set;
  logic [CNT_W-1:0]  starve_count;
  logic              starve_at_max;

  // Writes are refused while a swap waits so the back bank is stable at swap time.
  assign host_wr_ready = !hold_full && (state_q == IDLE);
  assign accept        = host_wr_valid && host_wr_ready;
  assign write_issue   = hold_full && !scan_req;

  assign mem_en    = scan_req || hold_full;
  assign mem_we    = write_issue;
  assign mem_addr  = scan_req ? {front_bank, scan_addr} : {~front_bank, hold_addr};
  assign mem_wdata = hold_data;
  assign swap_done = swap_fire;

  // One-entry holding register for the host write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_addr <= host_wr_addr;
      hold_data <= host_wr_data;
    end else if (write_issue) begin
      hold_full <= 1'b0;
    end
  end

  // Swap FSM state and front-bank register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      front_bank <= 1'b0;
    end else begin
      state_q    <= state_d;
      front_bank <= front_bank ^ swap_fire;
    end
  end

  // Swap next-state: fire only at a frame boundary with no write still held.
  always_comb begin
    state_d   = state_q;
    swap_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req) state_d = PEND;
      end
      PEND: begin
        if (frame_start && !hold_full) begin
          state_d   = IDLE;
          swap_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read return pipeline: RAM data lands one cycle after the request, then is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_req_d  <= 1'b0;
      scan_rvalid <= 1'b0;
      scan_rdata  <= '0;
    end else begin
      scan_req_d  <= scan_req;
      scan_rvalid <= scan_req_d;
      if (scan_req_d) scan_rdata <= mem_rdata;
    end
  end

  assign starve_inc = hold_full && scan_req;

  saturating_counter #(
    .N   (CNT_W),
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (starve_inc),
    .clr     (write_issue),
    .count   (starve_count),
    .at_max  (starve_at_max)
  );

  // Flag rises in the same edge the counter reaches the limit, not one later.
  assign starve_set = starve_at_max ||
                      (starve_inc && (starve_count == CNT_W'(STARVE_MAX - 1)));

  // Sticky starvation flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_starved <= 1'b0;
    end else if (starve_set) begin
      host_starved <= 1'b1;
    end else if (clear_status) begin
      host_starved <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: directed vector table, hand
// sequences for reset and starvation, then random traffic against a model.
module tb_frame_buffer_arbiter;

  localparam int AW = 12;
  localparam int DW = 24;
  localparam int MW = AW + 1;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_rdata;
  logic          scan_rvalid;
  logic          frame_start;
  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          swap_req;
  logic          swap_done;
  logic          front_bank;
  logic          clear_status;
  logic          host_starved;
  logic          mem_en;
  logic          mem_we;
  logic [MW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  frame_buffer_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SM)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .scan_req      (scan_req),
    .scan_addr     (scan_addr),
    .scan_rdata    (scan_rdata),
    .scan_rvalid   (scan_rvalid),
    .frame_start   (frame_start),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .swap_req      (swap_req),
    .swap_done     (swap_done),
    .front_bank    (front_bank),
    .clear_status  (clear_status),
    .host_starved  (host_starved),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  function automatic logic [DW-1:0] pat(input int unsigned i);
    logic [31:0] h;
    h = i * 32'h9E3779B1;
    return h[31:8];
  endfunction

  // Single-port synchronous RAM, preloadable with pat().
  logic [DW-1:0] ram [0:(1<<MW)-1];
  bit            ram_load = 1'b0;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < (1 << MW); i++) ram[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sr, input logic [AW-1:0] sa, input bit wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit swr, input bit fs, input bit clr);
    scan_req      = sr;
    scan_addr     = sa;
    host_wr_valid = wv;
    host_wr_addr  = wa;
    host_wr_data  = wd;
    swap_req      = swr;
    frame_start   = fs;
    clear_status  = clr;
  endtask

  // Reference model: bank contents, held write, swap intent, read returns.
  logic [DW-1:0] shadow [0:(1<<MW)-1];
  bit            m_hold, m_pend, m_front, m_starved, m_rv;
  logic [AW-1:0] m_haddr;
  logic [DW-1:0] m_hdata, m_rd;
  int            m_wait;
  logic [DW:0]   rpipe [$];

  task automatic model_reset();
    m_hold = 0; m_pend = 0; m_front = 0; m_starved = 0; m_rv = 0;
    m_haddr = '0; m_hdata = '0; m_rd = '0; m_wait = 0;
    rpipe.delete();
    for (int i = 0; i < (1 << MW); i++) shadow[i] = pat(i);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive(0, '0, 0, '0, '0, 0, 0, 0);
    reset_n  = 1'b0;
    ram_load = 1'b1;
    @(posedge clk); #1;
    ram_load = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", host_wr_ready, 1);
  endtask

  task automatic model_check();
    bit             e_en, e_we, e_rdy, e_done;
    logic [MW-1:0]  e_addr;
    e_rdy  = !m_hold && !m_pend;
    e_en   = scan_req || m_hold;
    e_we   = m_hold && !scan_req;
    e_done = m_pend && frame_start && !m_hold;
    e_addr = scan_req ? {m_front, scan_addr} : {!m_front, m_haddr};
    chk("rnd_ready", host_wr_ready, e_rdy);
    chk("rnd_en", mem_en, e_en);
    chk("rnd_we", mem_we, e_we);
    if (e_en) chk("rnd_addr", mem_addr, e_addr);
    if (e_we) chk("rnd_wdata", mem_wdata, m_hdata);
    chk("rnd_swap_done", swap_done, e_done);
    chk("rnd_front", front_bank, m_front);
    chk("rnd_rvalid", scan_rvalid, m_rv);
    chk("rnd_rdata", scan_rdata, m_rd);
    chk("rnd_starved", host_starved, m_starved);
  endtask

  task automatic model_step();
    bit          wr, done;
    int          nwait;
    logic [DW:0] entry;
    wr   = m_hold && !scan_req;
    done = m_pend && frame_start && !m_hold;
    entry = {scan_req, shadow[{m_front, scan_addr}]};
    if (rpipe.size() > 0) begin
      logic [DW:0] old;
      old = rpipe.pop_front();
      m_rv = old[DW];
      if (old[DW]) m_rd = old[DW-1:0];
    end
    rpipe.push_back(entry);
    if (wr)                        nwait = 0;
    else if (scan_req && m_hold)   nwait = (m_wait + 1 > SM) ? SM : m_wait + 1;
    else                           nwait = m_wait;
    if (m_wait == SM || nwait == SM) m_starved = 1;
    else if (clear_status)           m_starved = 0;
    m_wait = nwait;
    if (wr) begin
      shadow[{!m_front, m_haddr}] = m_hdata;
      m_hold = 0;
    end
    if (host_wr_valid && !m_hold && !m_pend && !wr) begin
      m_hold = 1; m_haddr = host_wr_addr; m_hdata = host_wr_data;
    end
    if (done) begin
      m_front = !m_front;
      m_pend  = 0;
    end else if (!m_pend && swap_req) begin
      m_pend = 1;
    end
  endtask

  typedef struct {
    bit            sr;   logic [AW-1:0] sa;
    bit            wv;   logic [AW-1:0] wa;  logic [DW-1:0] wd;
    bit            swr;  bit fs;
    bit            rdy;  bit en;  bit we;  logic [MW-1:0] ad;  logic [DW-1:0] wdx;
    bit            dn;   bit fr;  bit rv;  logic [DW-1:0] rd;
  } vec_t;

  function automatic vec_t mk(input bit sr, input logic [AW-1:0] sa, input bit wv,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input bit swr, input bit fs, input bit rdy, input bit en,
                              input bit we, input logic [MW-1:0] ad, input logic [DW-1:0] wdx,
                              input bit dn, input bit fr, input bit rv, input logic [DW-1:0] rd);
    vec_t v;
    v.sr = sr; v.sa = sa; v.wv = wv; v.wa = wa; v.wd = wd; v.swr = swr; v.fs = fs;
    v.rdy = rdy; v.en = en; v.we = we; v.ad = ad; v.wdx = wdx;
    v.dn = dn; v.fr = fr; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  initial begin
    vec_t tbl [$];
    reset_n = 1'b0;
    drive(0, '0, 0, '0, '0, 0, 0, 0);

    // Idle write, scan burst with a write pending, swap deferred by a held write,
    // swap_req ignored in PEND, swap_req coincident with frame_start.
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,0, 1,0,0,13'h0000,24'h0, 0,0, 0,24'h0));
    tbl.push_back(mk(0,12'h000, 1,12'h010,24'hFF8000, 0,0, 1,0,0,13'h0000,24'h0, 0,0, 0,24'h0));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,0, 0,1,1,13'h1010,24'hFF8000, 0,0, 0,24'h0));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,0, 1,0,0,13'h0000,24'h0, 0,0, 0,24'h0));
    tbl.push_back(mk(0,12'h000, 1,12'h020,24'h123456, 0,0, 1,0,0,13'h0000,24'h0, 0,0, 0,24'h0));
    tbl.push_back(mk(1,12'h000, 0,12'h000,24'h000000, 0,0, 0,1,0,13'h0000,24'h0, 0,0, 0,24'h0));
    tbl.push_back(mk(1,12'h001, 0,12'h000,24'h000000, 0,0, 0,1,0,13'h0001,24'h0, 0,0, 0,24'h0));
    tbl.push_back(mk(1,12'h002, 0,12'h000,24'h000000, 0,0, 0,1,0,13'h0002,24'h0, 0,0, 1,pat(0)));
    tbl.push_back(mk(1,12'h003, 0,12'h000,24'h000000, 0,0, 0,1,0,13'h0003,24'h0, 0,0, 1,pat(1)));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,0, 0,1,1,13'h1020,24'h123456, 0,0, 1,pat(2)));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,0, 1,0,0,13'h0000,24'h0, 0,0, 1,pat(3)));
    tbl.push_back(mk(1,12'h005, 1,12'h030,24'hABCDEF, 1,0, 1,1,0,13'h0005,24'h0, 0,0, 0,24'h0));
    tbl.push_back(mk(1,12'h006, 0,12'h000,24'h000000, 0,1, 0,1,0,13'h0006,24'h0, 0,0, 0,24'h0));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 1,0, 0,1,1,13'h1030,24'hABCDEF, 0,0, 1,pat(5)));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,0, 0,0,0,13'h0000,24'h0, 0,0, 1,pat(6)));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,1, 0,0,0,13'h0000,24'h0, 1,0, 0,24'h0));
    tbl.push_back(mk(1,12'h030, 0,12'h000,24'h000000, 0,0, 1,1,0,13'h1030,24'h0, 0,1, 0,24'h0));
    tbl.push_back(mk(1,12'h010, 0,12'h000,24'h000000, 0,0, 1,1,0,13'h1010,24'h0, 0,1, 0,24'h0));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 1,1, 1,0,0,13'h0000,24'h0, 0,1, 1,24'hABCDEF));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,0, 0,0,0,13'h0000,24'h0, 0,1, 1,24'hFF8000));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,1, 0,0,0,13'h0000,24'h0, 1,1, 0,24'h0));
    tbl.push_back(mk(0,12'h000, 0,12'h000,24'h000000, 0,0, 1,0,0,13'h0000,24'h0, 0,0, 0,24'h0));

    do_reset();
    chk("reset_front", front_bank, 0);
    chk("reset_rvalid", scan_rvalid, 0);
    chk("reset_rdata", scan_rdata, 0);
    chk("reset_starved", host_starved, 0);
    chk("reset_swap_done", swap_done, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      @(posedge clk); #1;
      drive(v.sr, v.sa, v.wv, v.wa, v.wd, v.swr, v.fs, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), host_wr_ready, v.rdy);
      chk($sformatf("vec%0d_en", i), mem_en, v.en);
      chk($sformatf("vec%0d_we", i), mem_we, v.we);
      if (v.en) chk($sformatf("vec%0d_addr", i), mem_addr, v.ad);
      if (v.we) chk($sformatf("vec%0d_wdata", i), mem_wdata, v.wdx);
      chk($sformatf("vec%0d_swap_done", i), swap_done, v.dn);
      chk($sformatf("vec%0d_front", i), front_bank, v.fr);
      chk($sformatf("vec%0d_rvalid", i), scan_rvalid, v.rv);
      if (v.rv) chk($sformatf("vec%0d_rdata", i), scan_rdata, v.rd);
    end

    // Asynchronous reset with a write held and a swap pending.
    do_reset();
    @(posedge clk); #1; drive(1, 12'h007, 1, 12'h040, 24'h777777, 1, 0, 0);
    @(posedge clk); #1; drive(1, 12'h008, 0, '0, '0, 0, 0, 0);
    @(negedge clk);     chk("rst_seq_ready_low", host_wr_ready, 0);
    @(posedge clk); #1; drive(1, 12'h009, 0, '0, '0, 0, 0, 0);
    @(negedge clk);
    chk("rst_seq_rvalid", scan_rvalid, 1);
    chk("rst_seq_rdata", scan_rdata, pat(7));
    #2; reset_n = 1'b0; drive(0, '0, 0, '0, '0, 0, 0, 0);
    #1;
    chk("async_rst_rvalid", scan_rvalid, 0);
    chk("async_rst_rdata", scan_rdata, 0);
    chk("async_rst_front", front_bank, 0);
    chk("async_rst_done", swap_done, 0);
    chk("async_rst_starved", host_starved, 0);
    chk("async_rst_ready", host_wr_ready, 1);
    chk("async_rst_we", mem_we, 0);
    @(posedge clk); #1; reset_n = 1'b1; frame_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_we", k), mem_we, 0);
      chk($sformatf("post_rst%0d_done", k), swap_done, 0);
      chk($sformatf("post_rst%0d_ready", k), host_wr_ready, 1);
      @(posedge clk); #1; drive(0, '0, 0, '0, '0, 0, 0, 0);
    end

    // Starvation: write held under continuous scan, flag sticky, clear/set priority.
    do_reset();
    @(posedge clk); #1; drive(1, 12'h000, 1, 12'h050, 24'h0A0B0C, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1; drive(1, AW'(k), 0, '0, '0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("starve_wait%0d", k), host_starved, (k == 9) ? 1 : 0);
    end
    @(posedge clk); #1; drive(1, 12'h00A, 0, '0, '0, 0, 0, 1);
    @(posedge clk); #1; drive(0, '0, 0, '0, '0, 0, 0, 0);
    @(negedge clk);
    chk("starve_clear_while_max", host_starved, 1);
    chk("starve_drain_we", mem_we, 1);
    chk("starve_drain_addr", mem_addr, 13'h1050);
    @(posedge clk); #1;
    @(negedge clk);     chk("starve_sticky_after_drain", host_starved, 1);
    @(posedge clk); #1; clear_status = 1'b1;
    @(posedge clk); #1; clear_status = 1'b0;
    @(negedge clk);     chk("starve_cleared", host_starved, 0);
    @(posedge clk); #1; drive(1, 12'h000, 1, 12'h060, 24'h0D0E0F, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1; drive(1, AW'(k), 0, '0, '0, 0, 0, (k == 8) ? 1'b1 : 1'b0);
      @(negedge clk);
      chk($sformatf("starve2_wait%0d", k), host_starved, 0);
    end
    @(posedge clk); #1; drive(1, 12'h009, 0, '0, '0, 0, 0, 0);
    @(negedge clk);     chk("starve_set_beats_clear", host_starved, 1);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int unsigned dense;
      dense = ((c / 200) % 2 == 0) ? 95 : 40;
      @(posedge clk); #1;
      drive($urandom_range(0, 99) < dense, AW'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), DW'($urandom),
            $urandom_range(0, 14) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0);
      @(negedge clk);
      model_check();
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
